// File: rtl/ps2_receiver.sv
// PS/2 keyboard-to-host receiver: synchronises and filters the pins, deframes
// 11-bit frames with odd parity, and hands good bytes out on a valid/ready register.
module ps2_receiver #(
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 27000
) (
  input  logic       clk,
  input  logic       reset_low,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       scan_code_valid,
  input  logic       scan_code_ready,
  output logic [7:0] scan_code_byte,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned FW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    rst_pipe;
  logic          rst_n;
  logic [1:0]    clk_sync, data_sync;
  logic [FW-1:0] clk_fcnt, data_fcnt;
  logic          clk_filt, data_filt, clk_filt_d;
  logic          sample;
  logic          accept;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] tcnt;

  // Reset asserts asynchronously but releases on a clock edge
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) rst_pipe <= '0;
    else            rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Filtered level follows only after FILTER_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt   <= 1'b1;
      data_filt  <= 1'b1;
      clk_fcnt   <= '0;
      data_fcnt  <= '0;
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        clk_fcnt <= '0;
      end else if (clk_fcnt == FILT_LAST) begin
        clk_filt <= clk_sync[1];
        clk_fcnt <= '0;
      end else begin
        clk_fcnt <= clk_fcnt + 1'b1;
      end
      if (data_sync[1] == data_filt) begin
        data_fcnt <= '0;
      end else if (data_fcnt == FILT_LAST) begin
        data_filt <= data_sync[1];
        data_fcnt <= '0;
      end else begin
        data_fcnt <= data_fcnt + 1'b1;
      end
    end
  end

  assign sample = clk_filt_d & ~clk_filt;
  assign accept = scan_code_valid & scan_code_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      bit_cnt         <= '0;
      shift           <= '0;
      par_bit         <= 1'b0;
      tcnt            <= '0;
      scan_code_valid <= 1'b0;
      scan_code_byte  <= '0;
      frame_error     <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      if (accept) scan_code_valid <= 1'b0;

      if (sample) begin
        // tcnt holds cycles elapsed since the most recent sample event
        tcnt <= TW'(1);
        case (state)
          S_IDLE: begin
            if (!data_filt) begin
              state   <= S_DATA;
              busy    <= 1'b1;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shift   <= {data_filt, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= data_filt;
            state   <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (!(^{shift, par_bit}) || !data_filt) begin
              frame_error <= 1'b1;
            end else if (!scan_code_valid || accept) begin
              scan_code_byte  <= shift;
              scan_code_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (state == S_IDLE) begin
        tcnt <= '0;
      end else if (tcnt == TMO_LAST) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        frame_error <= 1'b1;
        tcnt        <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule
